// File: rtl/matrix_scan_ctrl_if.sv
// Control bundle between the scan sequencer and its upstream/panel side.
// The slave modport is the sequencer; the master modport drives the enables.
interface matrix_scan_ctrl_if #(
    parameter int unsigned COLS  = 32,
    parameter int unsigned ROW_W = 4
);
    localparam int unsigned COL_W = $clog2(COLS);

    logic             en;
    logic             scroll_en;
    logic [COL_W-1:0] col_idx;
    logic             mclk;
    logic             lat;
    logic             oe_n;
    logic [ROW_W-1:0] row_addr;
    logic             shift;
    logic             frame_done;
    logic             busy;

    modport master (
        output en, scroll_en,
        input  col_idx, mclk, lat, oe_n, row_addr, shift, frame_done, busy
    );

    modport slave (
        input  en, scroll_en,
        output col_idx, mclk, lat, oe_n, row_addr, shift, frame_done, busy
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// RGB matrix scan sequencer: shifts a row, blanks, latches, displays, and
// issues a scroll pulse every SCROLL_FRAMES frames. All outputs are flops.
module matrix_scan_ctrl #(
    parameter int unsigned COLS          = 32,
    parameter int unsigned ROW_W         = 4,
    parameter int unsigned ON_CYCLES     = 64,
    parameter int unsigned SCROLL_FRAMES = 8
) (
    input logic               clk,
    input logic               rst,
    matrix_scan_ctrl_if.slave bus
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ON_W  = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
    localparam int unsigned FR_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_CYCLES - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(SCROLL_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] scan_row_q, scan_row_d;
    logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
    logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [ROW_W-1:0] row_addr_q, row_addr_d;
    logic             mclk_q, mclk_d;
    logic             lat_q, lat_d;
    logic             oe_n_q, oe_n_d;
    logic             shift_q, shift_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        scan_row_d   = scan_row_q;
        on_cnt_d     = on_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        row_addr_d   = row_addr_q;
        shift_d      = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d    = SHIFT_LO;
                    col_d      = '0;
                    scan_row_d = '0;
                end
            end
            SHIFT_LO: state_d = SHIFT_HI;
            SHIFT_HI: begin
                if (col_q == COL_LAST) begin
                    state_d = BLANK;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = SHIFT_LO;
                end
            end
            BLANK: begin
                // row_addr moves on LATCH entry, while the panel is still blanked
                state_d    = LATCH;
                row_addr_d = scan_row_q;
            end
            LATCH: begin
                state_d  = DISPLAY;
                on_cnt_d = '0;
            end
            DISPLAY: begin
                on_cnt_d = on_cnt_q + 1'b1;
                if (on_cnt_q == ON_LAST) begin
                    scan_row_d = scan_row_q + 1'b1;
                    if (scan_row_q == '1) begin
                        frame_done_d = 1'b1;
                        if (frame_cnt_q == FR_LAST) begin
                            frame_cnt_d = '0;
                            shift_d     = bus.scroll_en;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                    if (bus.en) begin
                        state_d = SHIFT_LO;
                        col_d   = '0;
                    end else begin
                        state_d    = IDLE;
                        scan_row_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Control outputs are registered from the next state so they line up with it.
        if (state_d == IDLE) begin
            col_d      = '0;
            row_addr_d = '0;
        end
        mclk_d = (state_d == SHIFT_HI);
        lat_d  = (state_d == LATCH);
        oe_n_d = (state_d != DISPLAY);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            scan_row_q   <= '0;
            on_cnt_q     <= '0;
            frame_cnt_q  <= '0;
            row_addr_q   <= '0;
            mclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            shift_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            scan_row_q   <= scan_row_d;
            on_cnt_q     <= on_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            row_addr_q   <= row_addr_d;
            mclk_q       <= mclk_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            shift_q      <= shift_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.col_idx    = col_q;
    assign bus.mclk       = mclk_q;
    assign bus.lat        = lat_q;
    assign bus.oe_n       = oe_n_q;
    assign bus.row_addr   = row_addr_q;
    assign bus.shift      = shift_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl: per-cycle expected outputs are queued
// from a row/frame model and popped against the DUT, then random invariants.
module tb_matrix_scan_ctrl;
    localparam int unsigned COLS = 4;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned ON_CYCLES = 3;
    localparam int unsigned SF = 2;
    localparam int ROW_LEN = 2 * COLS + 2 + ON_CYCLES;

    typedef struct packed {
        logic       mclk;
        logic       lat;
        logic       oe_n;
        logic       busy;
        logic       shift;
        logic       frame_done;
        logic [1:0] row_addr;
        logic [1:0] col_idx;
        logic       col_chk;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    int   m_fcnt;
    int   m_addr;
    logic pend_fd;
    logic pend_sh;

    matrix_scan_ctrl_if #(.COLS(COLS), .ROW_W(ROW_W)) bus ();

    matrix_scan_ctrl #(
        .COLS(COLS),
        .ROW_W(ROW_W),
        .ON_CYCLES(ON_CYCLES),
        .SCROLL_FRAMES(SF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic m, input logic l, input logic o, input logic b,
                                input logic s, input logic f, input int ra, input int ci,
                                input logic cc);
        exp_t e;
        e.mclk = m; e.lat = l; e.oe_n = o; e.busy = b;
        e.shift = s; e.frame_done = f;
        e.row_addr = 2'(ra); e.col_idx = 2'(ci); e.col_chk = cc;
        return e;
    endfunction

    task automatic check_next(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() > 0)
        else begin
            errors++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".mclk"}, 32'(bus.mclk), 32'(e.mclk));
            chk({tag, ".lat"}, 32'(bus.lat), 32'(e.lat));
            chk({tag, ".oe_n"}, 32'(bus.oe_n), 32'(e.oe_n));
            chk({tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
            chk({tag, ".shift"}, 32'(bus.shift), 32'(e.shift));
            chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(e.frame_done));
            chk({tag, ".row_addr"}, 32'(bus.row_addr), 32'(e.row_addr));
            if (e.col_chk) chk({tag, ".col_idx"}, 32'(bus.col_idx), 32'(e.col_idx));
        end
    endtask

    // act: 0 none, 1 drop en, 2 scroll_en=0, 3 scroll_en=1, 4 assert rst (row cut short)
    task automatic run_row(input int r, input int act_at, input int act);
        exp_t rowexp[ROW_LEN];
        int   cut;
        cut = (act == 4) ? act_at + 1 : ROW_LEN;
        for (int j = 0; j < 2 * COLS; j++)
            rowexp[j] = mk(logic'(j % 2), 1'b0, 1'b1, 1'b1,
                           (j == 0) ? pend_sh : 1'b0, (j == 0) ? pend_fd : 1'b0,
                           m_addr, j / 2, 1'b1);
        rowexp[2*COLS]   = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_addr, 0, 1'b0);
        rowexp[2*COLS+1] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r, 0, 1'b0);
        for (int j = 2 * COLS + 2; j < ROW_LEN; j++)
            rowexp[j] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r, 0, 1'b0);
        for (int j = 0; j < cut; j++) sb.push_back(rowexp[j]);
        pend_sh = 1'b0;
        pend_fd = 1'b0;
        m_addr  = r;
        for (int j = 0; j < cut; j++) begin
            @(posedge clk);
            #1;
            check_next($sformatf("row%0d.c%0d", r, j));
            if (j == act_at) begin
                case (act)
                    1: bus.en = 1'b0;
                    2: bus.scroll_en = 1'b0;
                    3: bus.scroll_en = 1'b1;
                    4: rst = 1'b1;
                    default: ;
                endcase
            end
        end
        if (act != 4 && r == 3) begin
            pend_fd = 1'b1;
            if (m_fcnt == SF - 1) begin
                m_fcnt  = 0;
                pend_sh = bus.scroll_en;
            end else begin
                m_fcnt++;
            end
        end
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, pend_sh, pend_fd, 0, 0, 1'b1));
            pend_sh = 1'b0;
            pend_fd = 1'b0;
            @(posedge clk);
            #1;
            check_next($sformatf("%s.c%0d", tag, j));
        end
        m_addr = 0;
    endtask

    task automatic run_frame(input int act0);
        run_row(0, 0, act0);
        for (int r = 1; r < 4; r++) run_row(r, 0, 0);
    endtask

    initial begin
        logic prev_shift, prev_fd, prev_oe_n;
        logic [1:0] prev_row;
        checks = 0; errors = 0;
        m_fcnt = 0; m_addr = 0; pend_fd = 1'b0; pend_sh = 1'b0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.scroll_en = 1'b1;

        // reset then enable; frames with scroll on
        check_idle(2, "reset");
        rst = 1'b0;
        bus.en = 1'b1;
        for (int f = 0; f < 4; f++) run_frame(0);

        // scroll disabled for three frames, re-enabled during the fourth
        run_frame(2);
        run_frame(0);
        run_frame(0);
        run_frame(3);

        // enable dropped during SHIFT_HI of row 1, col 2
        run_row(0, 0, 0);
        run_row(1, 5, 1);
        check_idle(3, "idle_after_drop");
        bus.en = 1'b1;
        run_frame(0);

        // reset in first DISPLAY cycle of row 2; frame count must restart
        run_row(0, 0, 0);
        run_row(1, 0, 0);
        run_row(2, 2 * COLS + 2, 4);
        m_fcnt = 0; pend_fd = 1'b0; pend_sh = 1'b0;
        check_idle(1, "mid_reset");
        rst = 1'b0;
        run_frame(0);
        run_frame(0);
        run_row(0, 0, 0);

        // random enables with invariant checks
        prev_shift = bus.shift;
        prev_fd = bus.frame_done;
        prev_oe_n = bus.oe_n;
        prev_row = bus.row_addr;
        for (int i = 0; i < 600; i++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            bus.scroll_en = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("inv_lat_oe", 32'(bus.lat & ~bus.oe_n), 32'd0);
            chk("inv_shift_width", 32'(bus.shift & prev_shift), 32'd0);
            chk("inv_fd_width", 32'(bus.frame_done & prev_fd), 32'd0);
            if (bus.shift) chk("inv_shift_oe", 32'(bus.oe_n), 32'd1);
            if (!bus.oe_n && !prev_oe_n) chk("inv_row_stable", 32'(bus.row_addr), 32'(prev_row));
            prev_shift = bus.shift;
            prev_fd = bus.frame_done;
            prev_oe_n = bus.oe_n;
            prev_row = bus.row_addr;
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Scan sequencer for the RGB LED matrix pipeline: drives the panel shift clock, latch, output-enable and row address, and supplies the column index used to fetch R0/G0/B0/R1/G1/B1 from the picture registers. Once per programmable number of frames it issues a one-cycle `shift` pulse to the picture register chain, which scrolls the image. Rows are shifted, latched and then displayed without overlap. Every control output is a registered flop.

## Interface
- `COLS`, 32: columns per row; shift clocks per row.
- `ROW_W`, 4: row address width; rows per half-panel = 2^ROW_W.
- `ON_CYCLES`, 64: cycles `oe_n` is held low per row (≥1).
- `SCROLL_FRAMES`, 8: frames between `shift` pulses (≥1).

- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable.
- `scroll_en`  in  1  allows `shift` pulses.
- `col_idx`  out  $clog2(COLS)  column whose pixel data must be presented on R0..B1.
- `mclk`  out  1  panel shift clock; the panel samples on the rising edge.
- `lat`  out  1  panel latch strobe.
- `oe_n`  out  1  panel output enable, active low.
- `row_addr`  out  ROW_W  displayed row pair.
- `shift`  out  1  one-cycle scroll pulse to the picture register chain.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Internal state:
  - `scan_row` (ROW_W bits): row currently being shifted.
  - `col` counter.
  - `on_cnt` counter.
  - `frame_cnt`, range 0..SCROLL_FRAMES-1.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY.
- IDLE:
  - Outputs are at their reset values.
  - `en`=1 → SHIFT_LO with col=0 and scan_row=0.
- SHIFT_LO: `mclk`=0, `col_idx`=col, `oe_n`=1 → SHIFT_HI.
- SHIFT_HI: `mclk`=1, `col_idx` held.
  - col==COLS-1 → BLANK.
  - Otherwise col+1 → SHIFT_LO.
- BLANK: `mclk`=0, `oe_n`=1, `lat`=0 → LATCH.
- LATCH: `lat`=1, `oe_n`=1, `row_addr` ← scan_row (loaded on entry) → DISPLAY with on_cnt=0.
- DISPLAY: `oe_n`=0, `lat`=0, on_cnt increments each cycle. When on_cnt==ON_CYCLES-1:
  - scan_row wraps modulo 2^ROW_W.
  - If scan_row was the last row:
    - `frame_done`=1 for the next cycle.
    - If frame_cnt==SCROLL_FRAMES-1, frame_cnt←0, and `shift`=1 in that same next cycle provided `scroll_en`=1.
    - Otherwise frame_cnt+1.
  - Next state: `en`=1 → SHIFT_LO with col=0; `en`=0 → IDLE with scan_row=0.
- `en` is sampled only in IDLE and on the last DISPLAY cycle. Dropping `en` mid-row finishes that row.
- frame_cnt advances regardless of `scroll_en`. With `scroll_en`=0, no pulse occurs and the count still wraps.
- `shift` and `frame_done` only assert in the first SHIFT_LO (or IDLE) cycle after a frame, while `oe_n`=1. The scroll therefore never changes data mid-display.

## Timing
- Reset values: `mclk`=0, `lat`=0, `oe_n`=1, `row_addr`=0, `col_idx`=0, `shift`=0, `frame_done`=0, `busy`=0. All counters are 0 and the state is IDLE.
- `rst` has priority over everything. Reset asserted mid-row gives reset values on the cycle after the sampling edge, with no partial latch.
- Start latency: `en` sampled high in IDLE at edge k → SHIFT_LO (`busy`=1, `col_idx`=0) in cycle k+1.
- Row length: 2·COLS + 2 + ON_CYCLES cycles.
- Frame length: 2^ROW_W × row length.
- `col_idx` is stable for the SHIFT_LO/SHIFT_HI pair. Data therefore has one full cycle of setup before the `mclk` rise.
- `lat` is never high while `oe_n`=0. `row_addr` changes only on LATCH entry, while `oe_n`=1.
- `shift` width is exactly one cycle. `frame_done` width is exactly one cycle.

## Test plan
Parameters for all scenarios: COLS=4, ROW_W=2, ON_CYCLES=3, SCROLL_FRAMES=2. Row = 13 cycles, frame = 52 cycles.

1. **Reset then enable.** Hold `rst`=1 for 2 cycles, release, then set `en`=1.
   - During reset all outputs are at reset values.
   - In the first cycle of row 0, `busy`=1 and `col_idx`=0.
   - `mclk` toggles in the pattern 0,1 ×4 while `col_idx` steps 0,0,1,1,2,2,3,3.
   - Then BLANK, LATCH (`lat`=1, `row_addr`=0), then `oe_n`=0 for 3 cycles.
2. **Frame and scroll cadence.** Hold `en`=1 and `scroll_en`=1 for 4 frames.
   - `row_addr` sequence is 0,1,2,3 repeating.
   - `frame_done` pulses every 52 cycles.
   - `shift` pulses on the 2nd and 4th `frame_done` only.
   - Each `shift` pulse occurs with `oe_n`=1.
3. **Scroll disabled.** Same as scenario 2 with `scroll_en`=0.
   - `shift` stays 0.
   - Asserting `scroll_en` after frame 1 yields a pulse at the end of frame 2.
4. **Enable drop mid-row.** Deassert `en` during SHIFT_HI of row 1, col 2.
   - Row 1 completes: `lat`, then 3 `oe_n`=0 cycles.
   - Then IDLE with `busy`=0 and `oe_n`=1.
   - Re-enabling restarts at `row_addr` latch value 0.
5. **Reset mid-operation.** Pulse `rst` during DISPLAY of row 2.
   - The next cycle shows reset values (`oe_n`=1).
   - frame_cnt is cleared: the next `shift` comes 2 full frames after restart.
6. **Invariant checker over random `en`/`scroll_en`.**
   - Never `lat`=1 with `oe_n`=0.
   - `row_addr` never changes while `oe_n`=0.
   - `shift` and `frame_done` are never high for more than 1 consecutive cycle.
